fifo_write_arbiter: RTL and testbench
=====================================

FIFO_WRITE_ARBITER -- requirements
Module: fifo_write_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, number of requesters sharing the FIFO write port (2..8).
REQ-002 Parameter DATA_WIDTH, default 8, FIFO data width.
REQ-003 Parameter BURST_LEN, default 4, maximum beats per grant (1..16).
REQ-004 write_clk  in  1  single clock; all logic on rising edge.
REQ-005 write_reset  in  1  synchronous, active-high reset.
REQ-006 req  in  NUM_REQ  per-requester write request; held high while data is pending.
REQ-007 req_data  in  NUM_REQ*DATA_WIDTH  packed requester data; requester k at bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-008 grant  out  NUM_REQ  one-hot current burst owner; all-zero when idle.
REQ-009 ack  out  NUM_REQ  beat accepted this cycle; requester advances its data on ack.
REQ-010 fifo_full  in  1  full flag from FIFO write side.
REQ-011 fifo_write_en  out  1  FIFO write enable.
REQ-012 fifo_write_data  out  DATA_WIDTH  FIFO write data.

Function
REQ-013 FSM states are IDLE and BURST; the owner index, beat counter and last-owner pointer are registers.
REQ-014 In IDLE, when any req bit is high, the arbiter SHALL select the first requester with req high, searching from last_owner+1 upward and wrapping NUM_REQ-1 -> 0, then enter BURST on the next edge.
REQ-015 Arbitration latency SHALL be exactly 1 cycle from req seen in IDLE to grant asserted; grant is never asserted in IDLE.
REQ-016 In BURST, ack[owner] = req[owner] & ~fifo_full, combinational; all other ack bits are 0.
REQ-017 fifo_write_en SHALL equal ack[owner], and fifo_write_data SHALL equal the owner's slice of req_data, both combinational.
REQ-018 The beat counter increments on each ack; BURST SHALL exit to IDLE after the ack that completes BURST_LEN beats.
REQ-019 If req[owner] is low in BURST, the arbiter SHALL exit to IDLE on that edge with no write.
REQ-020 While fifo_full is high in BURST, the arbiter SHALL stall: no write, grant held, beat counter held, and no timeout.
REQ-021 On every BURST exit, last_owner SHALL be loaded with owner, giving round-robin fairness.
REQ-022 With all requesters continuously active, the write-port duty cycle SHALL be BURST_LEN/(BURST_LEN+1).
REQ-023 fifo_write_en SHALL never be high in a cycle where fifo_full is high.

Reset
REQ-024 write_reset SHALL put the FSM in IDLE, clear the beat counter, and set last_owner to NUM_REQ-1 so that requester 0 wins first.
REQ-025 Outputs during and after reset: grant=0, ack=0, fifo_write_en=0; fifo_write_data follows req_data[0 slice].
REQ-026 Reset asserted mid-burst SHALL abort the burst on that edge; no write occurs in the reset cycle.

Configuration
REQ-027 Macro FIFO_WRITE_ARB_STATS_EN, when defined, SHALL add the output ports beat_total[15:0] and stall_cycles[15:0]:
- beat_total counts fifo_write_en cycles.
- stall_cycles counts BURST cycles with req[owner]&fifo_full.
- Both saturate at 16'hFFFF and are cleared by write_reset.
REQ-028 Without the macro, those ports and counters SHALL be absent, and all other behaviour is identical.

Structure
REQ-029 Shared package fifo_arb_pkg SHALL hold the FSM state encoding (IDLE=0, BURST=1) and the counter width constant STATS_W=16.
REQ-030 Sub-module rr_pick SHALL be the combinational round-robin selector (inputs: req vector, last_owner; outputs: valid, index), instantiated once.

Verification
REQ-031 Reset, then req=4'b0001 with 6 pending bytes 8'h00,8'h44,... -> grant=0001 one cycle later; 4 writes on consecutive cycles; 1 IDLE cycle; grant=0001 again; 2 writes.
REQ-032 req=4'b1111, fifo_full=0 held -> owner order 0,1,2,3,0; 4 writes per grant; one idle cycle between bursts.
REQ-033 fifo_full=1 after the 2nd beat of requester 2, held for 5 cycles -> fifo_write_en=0 and grant=0100 held for 5 cycles; the remaining 2 beats follow; never a write while full.
REQ-034 Owner 1 drops req after its 1st beat -> IDLE on the next edge; next grant goes to requester 2 if it is requesting, else wraps to 3, 0, 1.
REQ-035 write_reset pulsed mid-burst of requester 3 -> grant=0 that cycle; after release, with req=1111, requester 0 is granted first.
REQ-036 With FIFO_WRITE_ARB_STATS_EN defined, run scenario REQ-033 -> beat_total=4 and stall_cycles=5; with 70000 forced writes -> beat_total=16'hFFFF.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the FIFO write arbiter: FSM encoding, statistics
// counter width and a saturating-increment helper.
package fifo_arb_pkg;

    localparam int unsigned STATS_W = 16;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_e;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [STATS_W-1:0] sat_inc(input logic [STATS_W-1:0] v);
        return (v == {STATS_W{1'b1}}) ? v : v + STATS_W'(1);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first asserted request strictly after
// last_owner, wrapping from NUM_REQ-1 back to 0.
module rr_pick #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_owner,
    output logic               valid,
    output logic [IDX_W-1:0]   index
);

    logic [IDX_W-1:0] cand;

    // Walk the NUM_REQ positions after last_owner; last_owner itself is visited last.
    always_comb begin
        valid = 1'b0;
        index = '0;
        cand  = '0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            cand = IDX_W'((32'(last_owner) + i) % NUM_REQ);
            if (!valid && req[cand]) begin
                valid = 1'b1;
                index = cand;
            end
        end
    end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write port among NUM_REQ requesters.
// Define FIFO_WRITE_ARB_STATS_EN to add the beat_total / stall_cycles counters.
module fifo_write_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned BURST_LEN  = 4
) (
    input  logic                          write_clk,
    input  logic                          write_reset,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            grant,
    output logic [NUM_REQ-1:0]            ack,
    input  logic                          fifo_full,
    output logic                          fifo_write_en,
    output logic [DATA_WIDTH-1:0]         fifo_write_data
`ifdef FIFO_WRITE_ARB_STATS_EN
    ,
    output logic [STATS_W-1:0]            beat_total,
    output logic [STATS_W-1:0]            stall_cycles
`endif
);

    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CNT_W = $clog2(BURST_LEN + 1);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_REQ - 1);

    arb_state_e       state_q, state_d;
    logic [IDX_W-1:0] owner_q, owner_d;
    logic [IDX_W-1:0] last_q,  last_d;
    logic [CNT_W-1:0] beat_q,  beat_d;
    logic [IDX_W-1:0] data_idx;
    logic             pick_valid;
    logic [IDX_W-1:0] pick_idx;

    logic [DATA_WIDTH-1:0] req_slice [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_slice
        assign req_slice[g] = req_data[g*DATA_WIDTH +: DATA_WIDTH];
    end

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .req        (req),
        .last_owner (last_q),
        .valid      (pick_valid),
        .index      (pick_idx)
    );

    // State, owner, beat counter and round-robin pointer.
    always_ff @(posedge write_clk) begin
        if (write_reset) begin
            state_q <= IDLE;
            owner_q <= '0;
            last_q  <= LAST_IDX;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            beat_q  <= beat_d;
        end
    end

    // Next-state and combinational write-port outputs.
    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        last_d        = last_q;
        beat_d        = beat_q;
        grant         = '0;
        ack           = '0;
        fifo_write_en = 1'b0;
        data_idx      = write_reset ? '0 : owner_q;

        unique case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d = BURST;
                    owner_d = pick_idx;
                    beat_d  = '0;
                end
            end
            BURST: begin
                grant[owner_q] = 1'b1;
                if (!req[owner_q]) begin
                    // Requester ran dry: release the port without writing.
                    state_d = IDLE;
                    last_d  = owner_q;
                    beat_d  = '0;
                end else if (!fifo_full) begin
                    ack[owner_q]  = 1'b1;
                    fifo_write_en = 1'b1;
                    beat_d        = beat_q + CNT_W'(1);
                    if (beat_q == LAST_BEAT) begin
                        state_d = IDLE;
                        last_d  = owner_q;
                        beat_d  = '0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // A reset cycle never writes and never shows a grant.
        if (write_reset) begin
            grant         = '0;
            ack           = '0;
            fifo_write_en = 1'b0;
        end
    end

    assign fifo_write_data = req_slice[data_idx];

`ifdef FIFO_WRITE_ARB_STATS_EN
    logic stall_now;

    assign stall_now = (state_q == BURST) && req[owner_q] && fifo_full;

    // Saturating activity counters.
    always_ff @(posedge write_clk) begin
        if (write_reset) begin
            beat_total   <= '0;
            stall_cycles <= '0;
        end else begin
            if (fifo_write_en) begin
                beat_total <= sat_inc(beat_total);
            end
            if (stall_now) begin
                stall_cycles <= sat_inc(stall_cycles);
            end
        end
    end
`endif

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Scoreboard bench for fifo_write_arbiter: directed scenarios plus random traffic,
// checked cycle by cycle against a transaction-level reference model.
module tb_fifo_write_arbiter;

    localparam int unsigned NR = 4;
    localparam int unsigned DW = 8;
    localparam int unsigned BL = 4;
    localparam int unsigned IW = 2;

    logic              write_clk = 1'b0;
    logic              write_reset;
    logic [NR-1:0]     req;
    logic [NR*DW-1:0]  req_data;
    logic [NR-1:0]     grant;
    logic [NR-1:0]     ack;
    logic              fifo_full;
    logic              fifo_write_en;
    logic [DW-1:0]     fifo_write_data;
`ifdef FIFO_WRITE_ARB_STATS_EN
    logic [15:0]       beat_total;
    logic [15:0]       stall_cycles;
`endif

    always #5 write_clk = ~write_clk;

    fifo_write_arbiter #(
        .NUM_REQ    (NR),
        .DATA_WIDTH (DW),
        .BURST_LEN  (BL)
    ) dut (
        .write_clk       (write_clk),
        .write_reset     (write_reset),
        .req             (req),
        .req_data        (req_data),
        .grant           (grant),
        .ack             (ack),
        .fifo_full       (fifo_full),
        .fifo_write_en   (fifo_write_en),
        .fifo_write_data (fifo_write_data)
`ifdef FIFO_WRITE_ARB_STATS_EN
        ,
        .beat_total      (beat_total),
        .stall_cycles    (stall_cycles)
`endif
    );

    typedef struct {
        logic [NR-1:0] grant;
        logic [NR-1:0] ack;
        logic          wen;
        logic [DW-1:0] data;
        bit            chk_data;
        bit            chk_stats;
        int            beats;
        int            stalls;
    } exp_t;

    typedef struct {
        string name;
        int    act;
        int    exp;
    } dchk_t;

    exp_t  eq[$];
    dchk_t dq[$];
    int    glog[$];

    int n_checks = 0;
    int n_fail   = 0;
    int wr_obs   = 0;
    int stall_obs = 0;
    logic [NR-1:0] prev_grant = '0;

    // Requester side of the bench
    int            pending [NR];
    logic [DW-1:0] cur     [NR];
    bit            drop    [NR];
    int            ackcnt  [NR];
    bit            seq_data;

    // Reference model: one burst at a time, at most BL beats, round-robin pointer
    bit          m_busy, m_fresh, m_known;
    logic [IW-1:0] m_owner, m_last;
    int unsigned m_done;
    int          m_beats, m_stalls;

    function automatic int oh_idx(input logic [NR-1:0] v);
        for (int i = 0; i < NR; i++) if (v[i]) return i;
        return -1;
    endfunction

    function automatic int glog_at(input int i);
        return (i < glog.size()) ? glog[i] : -1;
    endfunction

    task automatic chk(input string n, input int a, input int x);
        n_checks++;
        if (a !== x) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", n, a, x, $time);
        end
    endtask

    task automatic post(input string n, input int a, input int x);
        dq.push_back('{name: n, act: a, exp: x});
    endtask

    task automatic model_cycle(input logic [NR-1:0] rq, input bit full, input bit rst,
                               output exp_t e);
        logic [IW-1:0] c;
        e.grant = '0; e.ack = '0; e.wen = 1'b0; e.data = '0; e.chk_data = 1'b0;
        e.chk_stats = m_known; e.beats = m_beats; e.stalls = m_stalls;
        if (rst) begin
            e.data = cur[0]; e.chk_data = 1'b1;
            m_busy = 1'b0; m_fresh = 1'b1; m_known = 1'b1;
            m_last = IW'(NR - 1); m_beats = 0; m_stalls = 0;
            return;
        end
        if (!m_busy) begin
            if (m_fresh) begin e.data = cur[0]; e.chk_data = 1'b1; end
            for (int j = 1; j <= NR; j++) begin
                c = IW'((int'(m_last) + j) % NR);
                if (!m_busy && rq[c]) begin
                    m_busy = 1'b1; m_owner = c; m_done = 0; m_fresh = 1'b0;
                end
            end
        end else begin
            e.grant = NR'(1) << m_owner;
            if (!rq[m_owner]) begin
                m_last = m_owner; m_busy = 1'b0;
            end else if (full) begin
                if (m_stalls < 65535) m_stalls++;
            end else begin
                e.ack = e.grant; e.wen = 1'b1; e.data = cur[m_owner]; e.chk_data = 1'b1;
                m_done++;
                if (m_beats < 65535) m_beats++;
                if (m_done == BL) begin m_last = m_owner; m_busy = 1'b0; end
            end
        end
    endtask

    // Drive one cycle, record the model's expectation, advance requesters on expected ack.
    task automatic step(input bit rst, input bit full);
        exp_t e;
        for (int k = 0; k < NR; k++) begin
            req[k] = (pending[k] > 0) && !drop[k];
            req_data[k*DW +: DW] = cur[k];
        end
        fifo_full   = full;
        write_reset = rst;
        model_cycle(req, full, rst, e);
        eq.push_back(e);
        for (int k = 0; k < NR; k++) begin
            if (e.ack[k]) begin
                pending[k]--;
                ackcnt[k]++;
                cur[k] = seq_data ? cur[k] + 8'h44 : DW'($urandom);
            end
        end
        @(posedge write_clk);
        #1;
    endtask

    task automatic clear_reqs();
        for (int k = 0; k < NR; k++) begin
            pending[k] = 0; drop[k] = 1'b0; ackcnt[k] = 0;
        end
    endtask

    // Monitor: compare every cycle against the scoreboard away from the active edge.
    always @(negedge write_clk) begin
        exp_t  e;
        dchk_t d;
        while (dq.size() != 0) begin
            d = dq.pop_front();
            chk(d.name, d.act, d.exp);
        end
        if (eq.size() != 0) begin
            e = eq.pop_front();
            chk("grant", int'(grant), int'(e.grant));
            chk("ack", int'(ack), int'(e.ack));
            chk("write_en", int'(fifo_write_en), int'(e.wen));
            if (e.chk_data) chk("write_data", int'(fifo_write_data), int'(e.data));
`ifdef FIFO_WRITE_ARB_STATS_EN
            if (e.chk_stats) begin
                chk("beat_total", int'(beat_total), e.beats);
                chk("stall_cycles", int'(stall_cycles), e.stalls);
            end
`endif
            chk("no_write_while_full", int'(fifo_write_en & fifo_full), 0);
            if (grant != '0 && prev_grant == '0) glog.push_back(oh_idx(grant));
            if (fifo_write_en) wr_obs++;
            if (grant != '0 && !fifo_write_en && fifo_full) stall_obs++;
            prev_grant = grant;
        end
    end

    initial begin
        int g0, w0, s0, n;
        bit r, f;
        write_reset = 1'b1; fifo_full = 1'b0; req = '0; req_data = '0;
        clear_reqs();
        for (int k = 0; k < NR; k++) cur[k] = '0;
        seq_data = 1'b1;
        m_busy = 1'b0; m_fresh = 1'b1; m_known = 1'b0;
        m_owner = '0; m_last = IW'(NR - 1); m_done = 0; m_beats = 0; m_stalls = 0;
        @(posedge write_clk);
        #1;

        // Single requester, six bytes: burst of 4, idle, burst of 2
        step(1, 0); step(1, 0);
        pending[0] = 6; cur[0] = 8'h00;
        g0 = glog.size(); w0 = wr_obs;
        repeat (14) step(0, 0);
        post("single_writes", wr_obs - w0, 6);
        post("single_grants", glog.size() - g0, 2);
        post("single_owner_a", glog_at(g0), 0);
        post("single_owner_b", glog_at(g0 + 1), 0);

        // All requesting: owner order 0,1,2,3,0 and 4 writes per 5 cycles
        step(1, 0);
        clear_reqs();
        for (int k = 0; k < NR; k++) pending[k] = 100;
        g0 = glog.size(); w0 = wr_obs;
        repeat (26) step(0, 0);
        post("rr_grants", glog.size() - g0, 5);
        for (int i = 0; i < 5; i++) post($sformatf("rr_owner_%0d", i), glog_at(g0 + i), i % NR);
        post("rr_writes", wr_obs - w0, 20);

        // FIFO full for 5 cycles after requester 2's second beat
        clear_reqs();
        step(1, 0);
        pending[2] = 4;
        s0 = stall_obs; w0 = wr_obs; n = 0;
        while (ackcnt[2] < 2 && n < 20) begin step(0, 0); n++; end
        post("full_reach_beat2", ackcnt[2], 2);
        repeat (5) step(0, 1);
        repeat (6) step(0, 0);
        post("full_stall_cycles", stall_obs - s0, 5);
        post("full_writes", wr_obs - w0, 4);
`ifdef FIFO_WRITE_ARB_STATS_EN
        post("stats_beat_total", int'(beat_total), 4);
        post("stats_stall_cycles", int'(stall_cycles), 5);
`endif

        // Owner 1 drops req after one beat; next grant goes to 2
        clear_reqs();
        step(1, 0);
        for (int k = 0; k < NR; k++) pending[k] = 50;
        g0 = glog.size(); n = 0;
        while (ackcnt[1] < 1 && n < 30) begin step(0, 0); n++; end
        post("drop_reach_beat1", ackcnt[1], 1);
        drop[1] = 1'b1;
        repeat (6) step(0, 0);
        post("drop_owner1_beats", ackcnt[1], 1);
        drop[1] = 1'b0;
        repeat (10) step(0, 0);
        for (int i = 0; i < 4; i++) post($sformatf("drop_owner_%0d", i), glog_at(g0 + i), i);

        // Reset mid-burst of requester 3; requester 0 wins afterwards
        clear_reqs();
        step(1, 0);
        pending[3] = 20; n = 0;
        while (ackcnt[3] < 2 && n < 20) begin step(0, 0); n++; end
        post("rst_reach_beat2", ackcnt[3], 2);
        for (int k = 0; k < NR; k++) pending[k] = 20;
        step(1, 0);
        g0 = glog.size();
        repeat (8) step(0, 0);
        post("rst_first_owner", glog_at(g0), 0);

        // Random traffic with back-pressure, drops and occasional reset
        seq_data = 1'b0;
        clear_reqs();
        repeat (1500) begin
            for (int k = 0; k < NR; k++) begin
                if (pending[k] == 0 && $urandom_range(0, 4) == 0) pending[k] = $urandom_range(1, 9);
                if ($urandom_range(0, 31) == 0) drop[k] = ~drop[k];
            end
            r = ($urandom_range(0, 199) == 0);
            f = ($urandom_range(0, 3) == 0);
            step(r, f);
        end

`ifdef FIFO_WRITE_ARB_STATS_EN
        // Enough writes to saturate beat_total
        clear_reqs();
        step(1, 0);
        pending[0] = 100000; n = 0;
        while (ackcnt[0] < 65600 && n < 90000) begin step(0, 0); n++; end
        post("sat_reach_writes", (ackcnt[0] >= 65600) ? 1 : 0, 1);
        post("sat_beat_total", int'(beat_total), 32'hFFFF);
`endif

        clear_reqs();
        repeat (3) step(0, 0);
        post("scoreboard_drained", eq.size(), 0);
        @(negedge write_clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
